// File: rtl/regex_imem_arbiter_pkg.sv
// Shared arbiter types: FSM state encoding and requester id width.
package regex_arb_package;

  typedef enum logic {
    S_FREE   = 1'b0,
    S_LOCKED = 1'b1
  } arb_state_e;

  localparam int ARB_N_CPU = 4;
  localparam int ARB_ID_W  = $clog2(ARB_N_CPU);

endpackage

// File: rtl/regex_imem_arbiter_find.sv
// Round-robin priority scan: first set request at or after ptr, cyclically.
module rr_find_first #(
  parameter int N_CPU = 4,
  parameter int ID_W  = $clog2(N_CPU)
) (
  input  logic [N_CPU-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  localparam logic [ID_W:0] N_L = (ID_W + 1)'(N_CPU);

  logic [2*N_CPU-1:0] dbl;
  logic [N_CPU-1:0]   rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  // Rotate the doubled request vector by ptr, pick the lowest set bit, map back.
  always_comb begin
    dbl   = {req, req};
    rot   = dbl[ptr +: N_CPU];
    found = |req;
    off   = '0;
    for (int k = N_CPU - 1; k >= 0; k--) begin
      if (rot[k]) off = k[ID_W-1:0];
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_L) sum = sum - N_L;
    idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/regex_imem_arbiter.sv
// Round-robin arbiter sharing one instruction BRAM read port among N_CPU regex CPUs.
module regex_imem_arbiter
  import regex_arb_package::*;
#(
  parameter int N_CPU             = ARB_N_CPU,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_WIDTH      = 16,
  parameter int CNT_WIDTH         = 32,
  localparam int ID_W             = $clog2(N_CPU)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_CPU-1:0]                   cpu_mem_valid,
  input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_mem_addr,
  output logic [N_CPU-1:0]                   cpu_mem_ready,
  output logic [MEMORY_WIDTH-1:0]            cpu_mem_data,
  output logic                               mem_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
  input  logic                               mem_ready,
  input  logic [MEMORY_WIDTH-1:0]            mem_data,
  output logic                               rsp_valid,
  output logic [ID_W-1:0]                    rsp_id,
  input  logic                               stat_clear,
  output logic [CNT_WIDTH-1:0]               stat_grants,
  output logic [CNT_WIDTH-1:0]               stat_conflicts
);

  localparam int AW = MEMORY_ADDR_WIDTH;

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      lock_q, lock_d;
  logic                 rsp_valid_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [CNT_WIDTH-1:0] grants_q, conflicts_q;

  logic [AW-1:0]   addr_arr [N_CPU];
  logic [ID_W-1:0] ff_idx;
  logic            ff_found;
  logic [ID_W-1:0] g;
  logic            accept;
  logic            conflict;

  // Saturating counter update; clear takes priority over increment.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] q,
                                                   input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && (q != '1)) return q + 1'b1;
    return q;
  endfunction

  for (genvar i = 0; i < N_CPU; i++) begin : g_addr
    assign addr_arr[i] = cpu_mem_addr[i*AW +: AW];
  end

  rr_find_first #(.N_CPU(N_CPU), .ID_W(ID_W)) u_find (
    .req   (cpu_mem_valid),
    .ptr   (rr_q),
    .idx   (ff_idx),
    .found (ff_found)
  );

  // Grant selection, BRAM request, per-CPU ready and next-state logic.
  always_comb begin
    state_d       = state_q;
    lock_d        = lock_q;
    rr_d          = rr_q;
    cpu_mem_ready = '0;
    conflict      = 1'b0;
    g             = (state_q == S_LOCKED) ? lock_q : ff_idx;
    mem_addr      = addr_arr[g];
    mem_valid     = !rst && ((state_q == S_LOCKED) || ff_found);
    accept        = mem_valid && mem_ready;
    if (accept) begin
      cpu_mem_ready[g] = 1'b1;
      rr_d = (g == ID_W'(N_CPU - 1)) ? '0 : g + 1'b1;
    end
    unique case (state_q)
      S_FREE: begin
        if (mem_valid && !mem_ready) begin
          state_d = S_LOCKED;
          lock_d  = g;
        end
      end
      S_LOCKED: begin
        if (accept) state_d = S_FREE;
      end
      default: state_d = S_FREE;
    endcase
    begin : pop
      int cnt;
      cnt = 0;
      for (int i = 0; i < N_CPU; i++) cnt += int'(cpu_mem_valid[i]);
      conflict = (cnt >= 2);
    end
  end

  // FSM, pointer, response tag and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FREE;
      rr_q        <= '0;
      lock_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      grants_q    <= '0;
      conflicts_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      rsp_valid_q <= accept;
      if (accept) rsp_id_q <= g;
      grants_q    <= sat_inc(grants_q, accept, stat_clear);
      conflicts_q <= sat_inc(conflicts_q, conflict, stat_clear);
    end
  end

  assign cpu_mem_data   = mem_data;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign stat_grants    = grants_q;
  assign stat_conflicts = conflicts_q;

  // A locked requester must keep its request raised until accepted.
  a_lock_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_LOCKED) |-> cpu_mem_valid[lock_q]);

endmodule

// File: tb/tb_regex_imem_arbiter.sv
module tb_regex_imem_arbiter;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cpu_mem_valid;
  logic [N*AW-1:0] cpu_mem_addr;
  logic [N-1:0]    cpu_mem_ready;
  logic [DW-1:0]   cpu_mem_data;
  logic            mem_valid;
  logic [AW-1:0]   mem_addr;
  logic            mem_ready;
  logic [DW-1:0]   mem_data;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic            stat_clear;
  logic [CW-1:0]   stat_grants;
  logic [CW-1:0]   stat_conflicts;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] A [N];

  regex_imem_arbiter #(
    .N_CPU(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_ready(cpu_mem_ready), .cpu_mem_data(cpu_mem_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .stat_clear(stat_clear), .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {5'b10101, a} ^ 16'h0F0F;
  endfunction

  // BRAM model: data valid one cycle after accept
  always @(posedge clk) begin
    if (mem_valid && mem_ready) mem_data <= memf(mem_addr);
  end

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
    end
  endtask

  typedef struct {
    bit       rst;
    bit [3:0] v;
    bit       rdy;
    bit       clr;
    int       gi;    // presented requester, -1 when mem_valid expected low
    bit       rspv;
    int       id;    // -1: rsp_id not checked
    int       g;
    int       c;
  } vec_t;

  function automatic vec_t mk(bit r, bit [3:0] v, bit rdy, bit clr, int gi,
                              bit rspv, int id, int g, int c);
    vec_t t;
    t.rst = r; t.v = v; t.rdy = rdy; t.clr = clr; t.gi = gi;
    t.rspv = rspv; t.id = id; t.g = g; t.c = c;
    return t;
  endfunction

  vec_t tbl [24];

  task automatic drive(input bit r, input bit [3:0] v, input bit rdy, input bit clr);
    @(posedge clk); #1;
    rst = r; cpu_mem_valid = v; mem_ready = rdy; stat_clear = clr;
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] last_addr;
    logic [3:0]    er;
    A[0] = 11'h020; A[1] = 11'h021; A[2] = 11'h005; A[3] = 11'h023;
    cpu_mem_addr = {A[3], A[2], A[1], A[0]};
    rst = 1'b1; cpu_mem_valid = '0; mem_ready = 1'b0; stat_clear = 1'b0;
    last_addr = '0;

    tbl[0]  = mk(0, 4'b0000, 1, 0, -1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 4'b0100, 1, 0,  2, 0,-1, 0, 0);
    tbl[2]  = mk(0, 4'b0000, 1, 0, -1, 1, 2, 1, 0);
    tbl[3]  = mk(1, 4'b0000, 1, 0, -1, 0,-1, 1, 0);
    tbl[4]  = mk(0, 4'b1111, 1, 0,  0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 4'b1111, 1, 0,  1, 1, 0, 1, 1);
    tbl[6]  = mk(0, 4'b1111, 1, 0,  2, 1, 1, 2, 2);
    tbl[7]  = mk(0, 4'b1111, 1, 0,  3, 1, 2, 3, 3);
    tbl[8]  = mk(0, 4'b1111, 1, 0,  0, 1, 3, 4, 4);
    tbl[9]  = mk(0, 4'b1111, 1, 0,  1, 1, 0, 5, 5);
    tbl[10] = mk(0, 4'b1111, 1, 0,  2, 1, 1, 6, 6);
    tbl[11] = mk(0, 4'b1111, 1, 0,  3, 1, 2, 7, 7);
    tbl[12] = mk(0, 4'b0000, 1, 0, -1, 1, 3, 8, 8);
    tbl[13] = mk(0, 4'b0010, 0, 0,  1, 0,-1, 8, 8);
    tbl[14] = mk(0, 4'b0011, 0, 0,  1, 0,-1, 8, 8);
    tbl[15] = mk(0, 4'b0011, 0, 0,  1, 0,-1, 8, 9);
    tbl[16] = mk(0, 4'b0011, 1, 0,  1, 0,-1, 8, 10);
    tbl[17] = mk(0, 4'b0001, 1, 0,  0, 1, 1, 9, 11);
    tbl[18] = mk(0, 4'b0000, 1, 0, -1, 1, 0, 10, 11);
    tbl[19] = mk(0, 4'b0100, 1, 0,  2, 0,-1, 10, 11);
    tbl[20] = mk(0, 4'b1001, 1, 0,  3, 1, 2, 11, 11);
    tbl[21] = mk(0, 4'b0001, 1, 0,  0, 1, 3, 12, 12);
    tbl[22] = mk(0, 4'b0001, 1, 1,  0, 1, 0, 13, 12);
    tbl[23] = mk(0, 4'b0000, 1, 0, -1, 1, 0, 0, 0);

    repeat (2) @(posedge clk);

    for (int r = 0; r < 24; r++) begin
      drive(tbl[r].rst, tbl[r].v, tbl[r].rdy, tbl[r].clr);
      er = '0;
      if (tbl[r].gi >= 0 && tbl[r].rdy && !tbl[r].rst) er[tbl[r].gi] = 1'b1;
      chk("mem_valid", r, 32'(mem_valid), 32'(tbl[r].gi >= 0));
      chk("cpu_mem_ready", r, 32'(cpu_mem_ready), 32'(er));
      if (tbl[r].gi >= 0) chk("mem_addr", r, 32'(mem_addr), 32'(A[tbl[r].gi]));
      chk("rsp_valid", r, 32'(rsp_valid), 32'(tbl[r].rspv));
      if (tbl[r].id >= 0) chk("rsp_id", r, 32'(rsp_id), 32'(tbl[r].id));
      if (tbl[r].rspv) chk("cpu_mem_data", r, 32'(cpu_mem_data), 32'(memf(last_addr)));
      chk("stat_grants", r, 32'(stat_grants), 32'(tbl[r].g));
      chk("stat_conflicts", r, 32'(stat_conflicts), 32'(tbl[r].c));
      if (er != '0) last_addr = A[tbl[r].gi];
    end

    // Saturation: 18 back-to-back contended accepts into 4-bit counters
    for (int k = 0; k < 18; k++) begin
      drive(0, 4'b1111, 1, 0);
      if (k == 15) begin
        chk("grants_at_max", 100, 32'(stat_grants), 32'd15);
        chk("conflicts_at_max", 100, 32'(stat_conflicts), 32'd15);
      end
    end
    drive(0, 4'b0000, 1, 0);
    chk("grants_saturated", 101, 32'(stat_grants), 32'd15);
    chk("conflicts_saturated", 101, 32'(stat_conflicts), 32'd15);

    // Reset while locked on CPU1
    drive(0, 4'b0010, 0, 0);
    chk("lock_mem_valid", 102, 32'(mem_valid), 32'd1);
    chk("lock_addr", 102, 32'(mem_addr), 32'(A[1]));
    drive(1, 4'b0010, 1, 0);
    chk("rst_mem_valid", 103, 32'(mem_valid), 32'd0);
    chk("rst_ready", 103, 32'(cpu_mem_ready), 32'd0);
    drive(0, 4'b0100, 1, 0);
    chk("post_rst_mem_valid", 104, 32'(mem_valid), 32'd1);
    chk("post_rst_ready", 104, 32'(cpu_mem_ready), 32'b0100);
    chk("post_rst_addr", 104, 32'(mem_addr), 32'(A[2]));
    chk("post_rst_rsp_valid", 104, 32'(rsp_valid), 32'd0);
    chk("post_rst_rsp_id", 104, 32'(rsp_id), 32'd0);
    chk("post_rst_grants", 104, 32'(stat_grants), 32'd0);
    chk("post_rst_conflicts", 104, 32'(stat_conflicts), 32'd0);
    drive(0, 4'b1001, 1, 0);
    chk("post_rst_wrap_grant", 105, 32'(cpu_mem_ready), 32'b1000);
    chk("post_rst_rsp_id2", 105, 32'(rsp_id), 32'd2);
    drive(0, 4'b0000, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
